// File: rtl/mult_accumulator_if.sv
// mult_accumulator_if: product-in / result-out handshake bundle for mult_accumulator.
// prod_last exists only when MULT_ACC_LAST_EN is defined.
interface mult_accumulator_if #(
    parameter int INPUT1_WIDTH = 4,
    parameter int INPUT2_WIDTH = 5,
    parameter int ACC_COUNT    = 4
);
    localparam int PROD_WIDTH = INPUT1_WIDTH + INPUT2_WIDTH;
    localparam int ACC_WIDTH  = PROD_WIDTH + $clog2(ACC_COUNT);
    localparam int CNT_WIDTH  = $clog2(ACC_COUNT);
    logic                  prod_valid;
    logic                  prod_ready;
    logic [PROD_WIDTH-1:0] product;
    logic                  clear;
    logic                  acc_valid;
    logic                  acc_ready;
    logic [ACC_WIDTH-1:0]  acc_data;
    logic [CNT_WIDTH-1:0]  beat_cnt;
`ifdef MULT_ACC_LAST_EN
    logic                  prod_last;
`endif
    modport master (
        output prod_valid, product, clear, acc_ready,
`ifdef MULT_ACC_LAST_EN
        output prod_last,
`endif
        input  prod_ready, acc_valid, acc_data, beat_cnt
    );
    modport slave (
        input  prod_valid, product, clear, acc_ready,
`ifdef MULT_ACC_LAST_EN
        input  prod_last,
`endif
        output prod_ready, acc_valid, acc_data, beat_cnt
    );
endinterface

// File: rtl/mult_accumulator.sv
// mult_accumulator: sums ACC_COUNT unsigned products per result over valid/ready handshakes.
// Defining MULT_ACC_LAST_EN adds prod_last to close a group early.
module mult_accumulator #(
    parameter int INPUT1_WIDTH = 4,
    parameter int INPUT2_WIDTH = 5,
    parameter int ACC_COUNT    = 4
) (
    input logic             clk,
    input logic             rst_n,
    mult_accumulator_if.slave bus
);
    localparam int PROD_WIDTH = INPUT1_WIDTH + INPUT2_WIDTH;
    localparam int ACC_WIDTH  = PROD_WIDTH + $clog2(ACC_COUNT);
    localparam int CNT_WIDTH  = $clog2(ACC_COUNT);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t               state, state_nxt;
    logic [ACC_WIDTH-1:0] acc, acc_nxt, sum, data_nxt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 valid_nxt, ready_nxt, fire, last_beat, close;
    assign fire = bus.prod_valid && bus.prod_ready;
    assign sum  = acc + ACC_WIDTH'(bus.product);
`ifdef MULT_ACC_LAST_EN
    assign last_beat = bus.beat_cnt == CNT_WIDTH'(ACC_COUNT - 1) || bus.prod_last;
`else
    assign last_beat = bus.beat_cnt == CNT_WIDTH'(ACC_COUNT - 1);
`endif
    assign close = fire && last_beat;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            acc            <= '0;
            bus.beat_cnt   <= '0;
            bus.acc_data   <= '0;
            bus.acc_valid  <= 1'b0;
            bus.prod_ready <= 1'b0;
        end else begin
            state          <= state_nxt;
            acc            <= acc_nxt;
            bus.beat_cnt   <= cnt_nxt;
            bus.acc_data   <= data_nxt;
            bus.acc_valid  <= valid_nxt;
            bus.prod_ready <= ready_nxt;
        end
    end
    always_comb begin
        state_nxt = state == IDLE  ? ACCUM
                  : state == ACCUM ? (!bus.clear && close ? HOLD : ACCUM)
                  : (bus.clear || bus.acc_ready ? ACCUM : HOLD);
    end
    // clear outranks both the beat handshake in ACCUM and acc_ready in HOLD
    always_comb begin
        acc_nxt   = acc;
        cnt_nxt   = bus.beat_cnt;
        data_nxt  = bus.acc_data;
        valid_nxt = bus.acc_valid;
        ready_nxt = bus.prod_ready;
        case (state)
            IDLE: ready_nxt = 1'b1;
            ACCUM: begin
                if (bus.clear) begin
                    acc_nxt = '0;
                    cnt_nxt = '0;
                end else if (close) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    data_nxt  = sum;
                    valid_nxt = 1'b1;
                    ready_nxt = 1'b0;
                end else if (fire) begin
                    acc_nxt = sum;
                    cnt_nxt = bus.beat_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (bus.clear || bus.acc_ready) begin
                    acc_nxt   = '0;
                    valid_nxt = 1'b0;
                    ready_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mult_accumulator.sv
// tb_mult_accumulator: directed plan plus randomized traffic checked every cycle
// against a queue-based model of group sums.
module tb_mult_accumulator;
    localparam int ACC_COUNT = 4;
`ifdef MULT_ACC_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   m_started, m_ready, m_valid;
    int   m_data;
    int   grp[$];
    mult_accumulator_if #(.INPUT1_WIDTH(4), .INPUT2_WIDTH(5), .ACC_COUNT(ACC_COUNT)) bus ();
    mult_accumulator #(.INPUT1_WIDTH(4), .INPUT2_WIDTH(5), .ACC_COUNT(ACC_COUNT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    // group-level view: a result is the plain sum of the accepted beats since the last close
    function automatic void model_step(input bit v, input int p, input bit c, input bit ar,
                                       input bit r, input bit l);
        if (!r) begin
            m_started = 0;
            m_ready   = 0;
            m_valid   = 0;
            m_data    = 0;
            grp.delete();
        end else if (!m_started) begin
            m_started = 1;
            m_ready   = 1;
        end else if (m_valid) begin
            if (c || ar) begin
                m_valid = 0;
                m_ready = 1;
            end
        end else if (c) begin
            grp.delete();
        end else if (v) begin
            grp.push_back(p);
            if (grp.size() == ACC_COUNT || (LAST_EN && l)) begin
                m_data  = grp.sum();
                m_valid = 1;
                m_ready = 0;
                grp.delete();
            end
        end
    endfunction
    task automatic cycle(input bit v, input int p, input bit c, input bit ar, input bit r,
                         input bit l);
        bus.prod_valid = v;
        bus.product    = 9'(p);
        bus.clear      = c;
        bus.acc_ready  = ar;
        rst_n          = r;
`ifdef MULT_ACC_LAST_EN
        bus.prod_last  = l;
`endif
        @(posedge clk);
        model_step(v, p, c, ar, r, l);
        @(negedge clk);
        check("prod_ready", int'(bus.prod_ready), int'(m_ready));
        check("acc_valid", int'(bus.acc_valid), int'(m_valid));
        check("acc_data", int'(bus.acc_data), m_data);
        check("beat_cnt", int'(bus.beat_cnt), grp.size());
    endtask
    initial begin
        bit cur_v = 0;
        bit took  = 0;
        int cur_p = 0;
        rst_n = 1'b0;
        bus.prod_valid = 1'b0;
        bus.product    = '0;
        bus.clear      = 1'b0;
        bus.acc_ready  = 1'b0;
`ifdef MULT_ACC_LAST_EN
        bus.prod_last  = 1'b0;
`endif
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("rst_ready", int'(bus.prod_ready), 0);
        cycle(1, 465, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 465, 0, 1, 1, 0);
        check("max_sum", int'(bus.acc_data), 1860);
        check("max_valid", int'(bus.acc_valid), 1);
        check("max_ready_low", int'(bus.prod_ready), 0);
        cycle(0, 0, 0, 1, 1, 0);
        check("max_ready_back", int'(bus.prod_ready), 1);
        for (int b = 1; b <= 4; b++) cycle(1, b, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 99, 0, 0, 1, 0);
            check("hold_data", int'(bus.acc_data), 10);
            check("hold_ready", int'(bus.prod_ready), 0);
        end
        cycle(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 7, 0, 0, 1, 0);
        check("sevens", int'(bus.acc_data), 28);
        cycle(0, 0, 0, 1, 1, 0);
        cycle(1, 100, 0, 1, 1, 0);
        cycle(1, 200, 0, 1, 1, 0);
        cycle(1, 50, 1, 1, 1, 0);
        check("clear_cnt", int'(bus.beat_cnt), 0);
        for (int b = 5; b <= 8; b++) cycle(1, b, 0, 0, 1, 0);
        check("after_clear", int'(bus.acc_data), 26);
        cycle(0, 0, 0, 1, 1, 0);
        for (int b = 1; b <= 4; b++) cycle(1, b, 0, 0, 1, 0);
        cycle(0, 0, 1, 1, 1, 0);
        check("clr_hold_valid", int'(bus.acc_valid), 0);
        check("clr_hold_ready", int'(bus.prod_ready), 1);
        cycle(1, 9, 0, 1, 1, 0);
        cycle(1, 9, 0, 1, 1, 0);
        cycle(1, 9, 0, 1, 0, 0);
        check("rst_mid_data", int'(bus.acc_data), 0);
        check("rst_mid_cnt", int'(bus.beat_cnt), 0);
        cycle(1, 1, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 1, 1, 0);
        check("post_rst_sum", int'(bus.acc_data), 4);
        cycle(0, 0, 0, 1, 1, 0);
`ifdef MULT_ACC_LAST_EN
        cycle(1, 10, 0, 0, 1, 0);
        cycle(1, 20, 0, 0, 1, 1);
        check("last_sum", int'(bus.acc_data), 30);
        check("last_valid", int'(bus.acc_valid), 1);
        cycle(0, 0, 0, 1, 1, 0);
        for (int b = 1; b <= 4; b++) cycle(1, b, 0, 0, 1, 0);
        check("after_last", int'(bus.acc_data), 10);
        cycle(0, 0, 0, 1, 1, 0);
`endif
        // producer keeps an unaccepted beat stable until the model says it was taken
        for (int i = 0; i < 3000; i++) begin
            if (!cur_v || took) begin
                cur_v = $urandom_range(0, 3) != 0;
                cur_p = int'($urandom_range(0, 465));
            end
            took = m_ready && cur_v;
            cycle(cur_v, cur_p, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) != 0, $urandom_range(0, 7) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
